// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, default PC width and
// the opcode field bounds inside a 32-bit instruction word.
package fetch_stage_pkg;

    localparam int PC_W_DEFAULT = 9;
    localparam int OPC_HI       = 6;
    localparam int OPC_LO       = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer {valid, pc, instr} that catches a fetch response
// arriving while decode is stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_wr,
    input  logic            i_clr,
    input  logic [PC_W-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [PC_W-1:0] o_pc,
    output logic [31:0]     o_instr
);

    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives instruction memory, fills the IF/ID register,
// parks a response in a skid buffer under stall, and drains stale requests on redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [6:0]      if_opcode
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_target;
    logic            r_if_valid;
    logic [PC_W-1:0] r_if_pc;
    logic [31:0]     r_if_instr;

    logic            w_slot_free;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_skid_wr;
    logic            w_skid_clr;
    logic            w_skid_valid;
    logic [PC_W-1:0] w_skid_pc;
    logic [31:0]     w_skid_instr;

    assign w_slot_free = !r_if_valid || !stall;
    assign w_pc_inc    = r_pc + PC_W'(4);
    assign w_skid_wr   = (r_state == ST_FETCH) && imem_ack && !redirect && !w_slot_free;
    assign w_skid_clr  = redirect || ((r_state == ST_HOLD) && !stall);

    fetch_skid_buf #(.PC_W(PC_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (w_skid_wr),
        .i_clr   (w_skid_clr),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    // r_pc is left on the abandoned address during DRAIN, so it serves both states.
    assign imem_req  = !reset && (r_state != ST_HOLD);
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= '0;
            r_target   <= '0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (redirect) begin
                        r_if_valid <= 1'b0;
                        if (imem_ack) begin
                            r_pc <= redirect_pc;
                        end else begin
                            r_target <= redirect_pc;
                            r_state  <= ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_inc;
                        if (w_slot_free) begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_rdata;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        r_if_valid <= 1'b0;
                        r_pc       <= redirect_pc;
                        r_state    <= ST_FETCH;
                    end else if (!stall) begin
                        r_if_valid <= w_skid_valid;
                        r_if_pc    <= w_skid_pc;
                        r_if_instr <= w_skid_instr;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    r_if_valid <= 1'b0;
                    if (imem_ack) begin
                        r_pc    <= redirect ? redirect_pc : r_target;
                        r_state <= ST_FETCH;
                    end else if (redirect) begin
                        r_target <= redirect_pc;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_opcode = r_if_instr[OPC_HI:OPC_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (PC_W=9).
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        if_valid;
    logic [8:0]  if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.PC_W(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] iword(input logic [8:0] a);
        return {16'hBEEF, 7'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_opcode", 32'(if_opcode), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // zero-wait streaming
        reset = 1'b0;
        #1;
        chk("req_after_rst", 32'(imem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1; imem_rdata = iword(9'(4*i));
            #1;
            chk("stream_addr", 32'(imem_addr), 32'(4*i));
            tick();
            chk("stream_valid", 32'(if_valid), 32'd1);
            chk("stream_pc", 32'(if_pc), 32'(4*i));
            chk("stream_instr", if_instr, iword(9'(4*i)));
        end
        chk("stream_opcode", 32'(if_opcode), 32'h0C);
        imem_ack = 1'b0;

        // stall while pc=8 is acked: skid, three stalled cycles, then release
        reset = 1'b1; tick(); reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = iword(9'h000); tick();
        imem_rdata = iword(9'h004); tick();
        chk("pre_stall_pc", 32'(if_pc), 32'h4);
        stall = 1'b1; imem_rdata = iword(9'h008);
        #1;
        chk("stall_addr", 32'(imem_addr), 32'h8);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD0001;   // ack with no request
        #1;
        chk("hold_req1", 32'(imem_req), 32'd0);
        chk("hold_pc1", 32'(if_pc), 32'h4);
        tick();
        chk("hold_req2", 32'(imem_req), 32'd0);
        tick();
        chk("hold_req3", 32'(imem_req), 32'd0);
        chk("hold_valid", 32'(if_valid), 32'd1);
        chk("hold_pc3", 32'(if_pc), 32'h4);
        stall = 1'b0; imem_ack = 1'b0;
        tick();
        chk("unstall_pc", 32'(if_pc), 32'h8);
        chk("unstall_instr", if_instr, iword(9'h008));
        chk("unstall_valid", 32'(if_valid), 32'd1);
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", 32'(imem_addr), 32'hC);
        tick();
        chk("bubble_valid", 32'(if_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = iword(9'h00C); tick();
        chk("after_bubble_pc", 32'(if_pc), 32'hC);
        chk("after_bubble_instr", if_instr, iword(9'h00C));
        imem_ack = 1'b0;

        // redirect + stall with live IF/ID, ack pending -> DRAIN
        stall = 1'b1; redirect = 1'b1; redirect_pc = 9'h040;
        tick();
        chk("redir_stall_valid", 32'(if_valid), 32'd0);
        stall = 1'b0; redirect = 1'b0;
        #1;
        chk("drain_addr", 32'(imem_addr), 32'h10);
        chk("drain_req", 32'(imem_req), 32'd1);
        tick();
        chk("drain_valid1", 32'(if_valid), 32'd0);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h5A5A5A5A;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("post_drain_addr", 32'(imem_addr), 32'h40);
        chk("post_drain_valid", 32'(if_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = iword(9'h040); tick();
        chk("target_pc", 32'(if_pc), 32'h40);
        chk("target_instr", if_instr, iword(9'h040));

        // redirect with ack in FETCH, then wrap from 0x1FC
        redirect = 1'b1; redirect_pc = 9'h1FC; imem_rdata = 32'h11111111;
        tick();
        redirect = 1'b0;
        chk("redir_ack_valid", 32'(if_valid), 32'd0);
        chk("redir_ack_addr", 32'(imem_addr), 32'h1FC);
        imem_rdata = iword(9'h1FC); tick();
        chk("wrap_pc", 32'(if_pc), 32'h1FC);
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        imem_ack = 1'b0;

        // later redirect in DRAIN overwrites saved target
        redirect = 1'b1; redirect_pc = 9'h100; tick();
        redirect_pc = 9'h120; tick();
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h22222222; tick();
        imem_ack = 1'b0;
        #1;
        chk("overwrite_addr", 32'(imem_addr), 32'h120);
        chk("overwrite_valid", 32'(if_valid), 32'd0);

        // reset during DRAIN; late ack during reset is ignored
        redirect = 1'b1; redirect_pc = 9'h080; tick();
        redirect = 1'b0; reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h33333333;
        #1;
        chk("rst_drain_req", 32'(imem_req), 32'd0);
        tick();
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        chk("rst_drain_valid", 32'(if_valid), 32'd0);
        chk("rst_drain_addr", 32'(imem_addr), 32'h000);
        chk("rst_drain_instr", if_instr, 32'd0);
        tick();
        chk("rst_drain_valid2", 32'(if_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = iword(9'h000); tick();
        imem_ack = 1'b0;
        chk("rst_drain_first_pc", 32'(if_pc), 32'h0);
        chk("rst_drain_first_valid", 32'(if_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
